// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the decode stage and its neighbours.
// Bus widths, LoongArch branch opcode constants and a small branch decoder.
// Optional feature macro used by id_stage: ID_FORWARD_EN (operand forwarding).
package pipe_pkg;

  localparam int IF_ID_W  = 69;   // {inst, pc, adef, ex_ade, ex_tlbr, ex_pif, ex_ppi}
  localparam int ID_EX_W  = 133;  // {inst, pc, rj_val, rkd_val, ex[4:0]}
  localparam int FWD_W    = 40;   // EX/MEM forward bus
  localparam int WB_FWD_W = 39;   // WB forward bus

  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;
  localparam logic [7:0] OP8_ST  = 8'h29;     // store group, rd is a source

  typedef enum logic [3:0] {
    BR_NONE, BR_JIRL, BR_B, BR_BL, BR_BEQ, BR_BNE,
    BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
  } br_kind_e;

  function automatic br_kind_e decode_br(input logic [5:0] op);
    case (op)
      OP_JIRL: decode_br = BR_JIRL;
      OP_B:    decode_br = BR_B;
      OP_BL:   decode_br = BR_BL;
      OP_BEQ:  decode_br = BR_BEQ;
      OP_BNE:  decode_br = BR_BNE;
      OP_BLT:  decode_br = BR_BLT;
      OP_BGE:  decode_br = BR_BGE;
      OP_BLTU: decode_br = BR_BLTU;
      OP_BGEU: decode_br = BR_BGEU;
      default: decode_br = BR_NONE;
    endcase
  endfunction

  // Conditional branches occupy one contiguous opcode range.
  function automatic logic is_cond_br(input logic [5:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGEU);
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of all decode-stage connections except clk/reset.
// Handshake: a word moves IF->ID on a cycle where IF_to_ID_valid && ID_allow,
// and ID->EX on a cycle where ID_to_EX_valid && EX_allow; a producer holds its
// bus stable while valid is high and the consumer is not ready.
// Modports: master = surrounding pipeline, slave = id_stage.
// dbg_id_valid / dbg_br_done expose the stage's internal state bits.
// Optional feature macro affecting id_stage: ID_FORWARD_EN.
interface id_stage_if;
  import pipe_pkg::*;

  logic                IF_to_ID_valid;
  logic [IF_ID_W-1:0]  IF_to_ID_bus;
  logic                ID_allow;
  logic                EX_allow;
  logic                ID_to_EX_valid;
  logic [ID_EX_W-1:0]  ID_to_EX_bus;
  logic [32:0]         branch_bus;
  logic                ID_br_stall;
  logic                flush;
  logic [4:0]          rf_raddr1;
  logic [4:0]          rf_raddr2;
  logic [31:0]         rf_rdata1;
  logic [31:0]         rf_rdata2;
  logic [FWD_W-1:0]    EX_fwd;
  logic [FWD_W-1:0]    MEM_fwd;
  logic [WB_FWD_W-1:0] WB_fwd;
  logic                dbg_id_valid;
  logic                dbg_br_done;

  modport master (
    output IF_to_ID_valid, IF_to_ID_bus, EX_allow, flush,
           rf_rdata1, rf_rdata2, EX_fwd, MEM_fwd, WB_fwd,
    input  ID_allow, ID_to_EX_valid, ID_to_EX_bus, branch_bus, ID_br_stall,
           rf_raddr1, rf_raddr2, dbg_id_valid, dbg_br_done
  );

  modport slave (
    input  IF_to_ID_valid, IF_to_ID_bus, EX_allow, flush,
           rf_rdata1, rf_rdata2, EX_fwd, MEM_fwd, WB_fwd,
    output ID_allow, ID_to_EX_valid, ID_to_EX_bus, branch_bus, ID_br_stall,
           rf_raddr1, rf_raddr2, dbg_id_valid, dbg_br_done
  );

endinterface

// File: rtl/id_branch_unit.sv
// Branch decode, condition evaluation and target calculation for ID.
// Ports: i_inst/i_pc of the instruction in ID, i_rj_val/i_rkd_val resolved
// operands; o_is_branch, o_taken, o_target (32-bit wraparound adds).
// Not affected by ID_FORWARD_EN.
module id_branch_unit
  import pipe_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rj_val,
  input  logic [31:0] i_rkd_val,
  output logic        o_is_branch,
  output logic        o_taken,
  output logic [31:0] o_target
);

  br_kind_e    w_kind;
  logic [31:0] w_offs16;
  logic [31:0] w_offs26;

  assign w_kind   = decode_br(i_inst[31:26]);
  assign w_offs16 = {{14{i_inst[25]}}, i_inst[25:10], 2'b00};
  // b/bl keep the high offset bits in inst[9:0]
  assign w_offs26 = {{4{i_inst[9]}}, i_inst[9:0], i_inst[25:10], 2'b00};

  always_comb begin
    o_is_branch = (w_kind != BR_NONE);
    o_taken     = 1'b0;
    o_target    = i_pc + w_offs16;
    case (w_kind)
      BR_JIRL: begin o_taken = 1'b1; o_target = i_rj_val + w_offs16; end
      BR_B,
      BR_BL:   begin o_taken = 1'b1; o_target = i_pc + w_offs26; end
      BR_BEQ:  o_taken = (i_rj_val == i_rkd_val);
      BR_BNE:  o_taken = (i_rj_val != i_rkd_val);
      BR_BLT:  o_taken = ($signed(i_rj_val) <  $signed(i_rkd_val));
      BR_BGE:  o_taken = ($signed(i_rj_val) >= $signed(i_rkd_val));
      BR_BLTU: o_taken = (i_rj_val <  i_rkd_val);
      BR_BGEU: o_taken = (i_rj_val >= i_rkd_val);
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: holds one IF word, reads/forwards operands,
// detects hazards, resolves branches and hands the word to EX.
// Ports: clk, reset (synchronous, active-high), bus (id_stage_if.slave).
// Macro ID_FORWARD_EN: defined -> operands forwarded EX > MEM > WB > regfile,
// stall only on EX load/csr or MEM data_pending; undefined -> regfile only,
// stall on any matching producer in EX, MEM or WB.
module id_stage
  import pipe_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  id_stage_if.slave bus
);

  logic               r_id_valid;
  logic               r_br_done;
  logic [IF_ID_W-1:0] r_id_bus;

  logic [31:0] w_inst, w_pc, w_rj_val, w_rkd_val, w_target;
  logic [4:0]  w_ex, w_src1, w_src2;
  logic        w_has_ex, w_hazard, w_ready_go, w_id_allow;
  logic        w_is_branch, w_taken, w_br_fire;
  logic        w_ex1, w_ex2, w_mem1, w_mem2, w_wb1, w_wb2;

  // r0 never matches a producer
  function automatic logic hit(input logic v, input logic we,
                               input logic [4:0] d, input logic [4:0] s);
    return v & we & (d == s) & (s != 5'd0);
  endfunction

  assign w_inst   = r_id_bus[68:37];
  assign w_pc     = r_id_bus[36:5];
  assign w_ex     = r_id_bus[4:0];
  assign w_has_ex = |w_ex;

  assign w_src1 = w_inst[9:5];
  assign w_src2 = (is_cond_br(w_inst[31:26]) || (w_inst[31:24] == OP8_ST))
                  ? w_inst[4:0] : w_inst[14:10];

  assign w_ex1  = hit(bus.EX_fwd[39],  bus.EX_fwd[38],  bus.EX_fwd[36:32],  w_src1);
  assign w_ex2  = hit(bus.EX_fwd[39],  bus.EX_fwd[38],  bus.EX_fwd[36:32],  w_src2);
  assign w_mem1 = hit(bus.MEM_fwd[39], bus.MEM_fwd[38], bus.MEM_fwd[36:32], w_src1);
  assign w_mem2 = hit(bus.MEM_fwd[39], bus.MEM_fwd[38], bus.MEM_fwd[36:32], w_src2);
  assign w_wb1  = hit(bus.WB_fwd[38],  bus.WB_fwd[37],  bus.WB_fwd[36:32],  w_src1);
  assign w_wb2  = hit(bus.WB_fwd[38],  bus.WB_fwd[37],  bus.WB_fwd[36:32],  w_src2);

`ifdef ID_FORWARD_EN
  always_comb begin
    w_rj_val = bus.rf_rdata1;
    if (w_src1 == 5'd0) w_rj_val = 32'd0;
    else if (w_ex1)     w_rj_val = bus.EX_fwd[31:0];
    else if (w_mem1)    w_rj_val = bus.MEM_fwd[31:0];
    else if (w_wb1)     w_rj_val = bus.WB_fwd[31:0];
    w_rkd_val = bus.rf_rdata2;
    if (w_src2 == 5'd0) w_rkd_val = 32'd0;
    else if (w_ex2)     w_rkd_val = bus.EX_fwd[31:0];
    else if (w_mem2)    w_rkd_val = bus.MEM_fwd[31:0];
    else if (w_wb2)     w_rkd_val = bus.WB_fwd[31:0];
  end
  // Only producers whose data is not yet available force a wait.
  assign w_hazard = ((w_ex1 | w_ex2) & bus.EX_fwd[37]) |
                    ((w_mem1 | w_mem2) & bus.MEM_fwd[37]);
`else
  logic w_unused_fwd;
  assign w_rj_val  = (w_src1 == 5'd0) ? 32'd0 : bus.rf_rdata1;
  assign w_rkd_val = (w_src2 == 5'd0) ? 32'd0 : bus.rf_rdata2;
  assign w_hazard  = w_ex1 | w_ex2 | w_mem1 | w_mem2 | w_wb1 | w_wb2;
  assign w_unused_fwd = ^{bus.EX_fwd[37], bus.EX_fwd[31:0], bus.MEM_fwd[37],
                          bus.MEM_fwd[31:0], bus.WB_fwd[31:0]};
`endif

  // An excepting word carries no real operands: never wait, never redirect.
  assign w_ready_go = ~w_hazard | w_has_ex;
  assign w_id_allow = ~r_id_valid | (w_ready_go & bus.EX_allow);

  id_branch_unit u_branch (
    .i_inst      (w_inst),
    .i_pc        (w_pc),
    .i_rj_val    (w_rj_val),
    .i_rkd_val   (w_rkd_val),
    .o_is_branch (w_is_branch),
    .o_taken     (w_taken),
    .o_target    (w_target)
  );

  // br_done makes the redirect a single pulse while the branch waits on EX.
  assign w_br_fire = r_id_valid & w_is_branch & w_taken & w_ready_go & ~r_br_done
                     & ~bus.flush & ~w_has_ex & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_valid <= 1'b0;
      r_br_done  <= 1'b0;
      r_id_bus   <= '0;
    end else if (bus.flush) begin
      r_id_valid <= 1'b0;
      r_br_done  <= 1'b0;
    end else begin
      if (w_br_fire) r_br_done <= 1'b1;
      if (w_id_allow) begin
        r_id_valid <= bus.IF_to_ID_valid;
        if (bus.IF_to_ID_valid) begin
          r_id_bus  <= bus.IF_to_ID_bus;
          r_br_done <= 1'b0;
        end
      end
    end
  end

  assign bus.ID_allow       = w_id_allow;
  assign bus.ID_to_EX_valid = r_id_valid & w_ready_go & ~bus.flush;
  assign bus.ID_to_EX_bus   = {w_inst, w_pc, w_rj_val, w_rkd_val, w_ex};
  assign bus.branch_bus     = w_br_fire ? {1'b1, w_target} : 33'd0;
  assign bus.ID_br_stall    = r_id_valid & w_is_branch & ~w_ready_go;
  assign bus.rf_raddr1      = w_src1;
  assign bus.rf_raddr2      = w_src2;
  assign bus.dbg_id_valid   = r_id_valid;
  assign bus.dbg_br_done    = r_br_done;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the decode stage. Honours ID_FORWARD_EN.
module tb_id_stage;
  import pipe_pkg::*;

  logic clk;
  logic reset;
  id_stage_if bus();

  id_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file stimulus ----------------
  logic [31:0] rf [32];
  always_comb begin
    bus.rf_rdata1 = rf[bus.rf_raddr1];
    bus.rf_rdata2 = rf[bus.rf_raddr2];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  logic [ID_EX_W-1:0] exp_q[$];

  logic               m_valid;
  logic               m_redirected;
  logic [IF_ID_W-1:0] m_word;

  task automatic check(input string tag, input logic [132:0] got, input logic [132:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Operand value and "must wait" for one source register.
  task automatic operand(input logic [4:0] s, output logic [31:0] v, output bit blk);
    bit exm, memm, wbm;
    exm  = bus.EX_fwd[39]  && bus.EX_fwd[38]  && (bus.EX_fwd[36:32]  == s);
    memm = bus.MEM_fwd[39] && bus.MEM_fwd[38] && (bus.MEM_fwd[36:32] == s);
    wbm  = bus.WB_fwd[38]  && bus.WB_fwd[37]  && (bus.WB_fwd[36:32]  == s);
    v = rf[s];
    blk = 0;
    if (s == 5'd0) begin
      v = 32'd0;
    end else begin
`ifdef ID_FORWARD_EN
      if (exm)       v = bus.EX_fwd[31:0];
      else if (memm) v = bus.MEM_fwd[31:0];
      else if (wbm)  v = bus.WB_fwd[31:0];
      blk = (exm && bus.EX_fwd[37]) || (memm && bus.MEM_fwd[37]);
`else
      blk = exm || memm || wbm;
`endif
    end
  endtask

  task automatic branch_model(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] a, input logic [31:0] b,
                              output bit isbr, output bit tk, output logic [31:0] tgt);
    logic [31:0] o16;
    logic [31:0] o26;
    o16 = {{16{inst[25]}}, inst[25:10]};
    o26 = {{6{inst[9]}}, inst[9:0], inst[25:10]};
    isbr = 1; tk = 0; tgt = pc + o16 * 4;
    case (inst[31:26])
      6'h13:        begin tk = 1; tgt = a + o16 * 4; end
      6'h14, 6'h15: begin tk = 1; tgt = pc + o26 * 4; end
      6'h16: tk = (a == b);
      6'h17: tk = (a != b);
      6'h18: tk = ($signed(a) <  $signed(b));
      6'h19: tk = ($signed(a) >= $signed(b));
      6'h1a: tk = (a <  b);
      6'h1b: tk = (a >= b);
      default: isbr = 0;
    endcase
  endtask

  // Compare DUT outputs mid-cycle, then advance the model over the next edge.
  task automatic sample();
    logic [31:0] inst, pc, a, b, tgt;
    logic [4:0]  exv, s1, s2;
    bit blk1, blk2, ready, isbr, tk, bv, allow, out_v;
    @(negedge clk);
    inst = m_word[68:37]; pc = m_word[36:5]; exv = m_word[4:0];
    s1 = inst[9:5];
    s2 = (((inst[31:26] >= 6'h16) && (inst[31:26] <= 6'h1b)) || (inst[31:24] == 8'h29))
         ? inst[4:0] : inst[14:10];
    operand(s1, a, blk1);
    operand(s2, b, blk2);
    ready = !(blk1 || blk2) || (exv != 0);
    branch_model(inst, pc, a, b, isbr, tk, tgt);
    allow = !m_valid || (ready && bus.EX_allow);
    out_v = m_valid && ready && !bus.flush;
    bv = m_valid && isbr && tk && ready && !m_redirected && !bus.flush && (exv == 0) && !reset;

    check("id_allow", bus.ID_allow, allow);
    check("id_to_ex_valid", bus.ID_to_EX_valid, out_v);
    check("br_stall", bus.ID_br_stall, m_valid && isbr && !ready);
    check("branch_bus", bus.branch_bus, bv ? {1'b1, tgt} : 33'd0);
    check("rf_raddr1", bus.rf_raddr1, s1);
    check("rf_raddr2", bus.rf_raddr2, s2);
    check("dbg_id_valid", bus.dbg_id_valid, m_valid);
    if (bus.branch_bus[32]) pulses++;

    if (out_v && bus.EX_allow) exp_q.push_back({inst, pc, a, b, exv});
    if (bus.ID_to_EX_valid && bus.EX_allow) begin
      if (exp_q.size() == 0) check("ex_handoff_extra", exp_q.size(), 1);
      else check("ex_handoff", bus.ID_to_EX_bus, exp_q.pop_front());
    end

    if (reset) begin
      m_valid = 0; m_redirected = 0; m_word = '0;
    end else if (bus.flush) begin
      m_valid = 0; m_redirected = 0;
    end else begin
      if (bv) m_redirected = 1;
      if (allow) begin
        m_valid = bus.IF_to_ID_valid;
        if (bus.IF_to_ID_valid) begin
          m_word = bus.IF_to_ID_bus;
          m_redirected = 0;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.IF_to_ID_valid = 0;
    bus.IF_to_ID_bus   = '0;
    bus.EX_allow       = 1;
    bus.flush          = 0;
    bus.EX_fwd         = '0;
    bus.MEM_fwd        = '0;
    bus.WB_fwd         = '0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] offs,
                                     input logic [4:0] rj, input logic [4:0] rd);
    return {op, offs, rj, rd};
  endfunction

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [4:0] ex);
    idle();
    bus.IF_to_ID_valid = 1;
    bus.IF_to_ID_bus   = {inst, pc, ex};
    sample();
    advance();
    idle();
  endtask

  task automatic rand_inputs();
    logic [31:0] inst;
    inst = $urandom;
    case ($urandom_range(0, 2))
      0: inst[31:26] = 6'($urandom_range(6'h13, 6'h1b));
      1: inst[31:24] = 8'h29;
      default: ;
    endcase
    inst[14:10] = 5'($urandom_range(0, 3));
    inst[9:5]   = 5'($urandom_range(0, 3));
    inst[4:0]   = 5'($urandom_range(0, 3));
    bus.IF_to_ID_valid = 1'($urandom_range(0, 1));
    bus.IF_to_ID_bus   = {inst, $urandom & 32'hffff_fffc,
                          ($urandom_range(0, 9) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0};
    bus.EX_allow = ($urandom_range(0, 3) != 0);
    bus.flush    = ($urandom_range(0, 19) == 0);
    reset        = ($urandom_range(0, 99) == 0);
    bus.EX_fwd  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)), $urandom};
    bus.MEM_fwd = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)), $urandom};
    bus.WB_fwd  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), $urandom};
    if ($urandom_range(0, 7) == 0)
      for (int i = 1; i < 4; i++)
        rf[i] = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 2)) : $urandom;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hdead_beef;  // r0 must read as zero regardless
    rf[1] = 32'd5;
    rf[2] = 32'd5;
    m_valid = 0; m_redirected = 0; m_word = '0;
    reset = 1;
    idle();
    advance();

    // reset state
    sample();
    check("rst_allow", bus.ID_allow, 1'b1);
    check("rst_out_valid", bus.ID_to_EX_valid, 1'b0);
    check("rst_branch_bus", bus.branch_bus, 33'd0);
    check("rst_stall", bus.ID_br_stall, 1'b0);
    advance();
    reset = 0;

    // beq r1,r2 equal: one-cycle redirect to pc+16
    send(mk(6'h16, 16'd4, 5'd1, 5'd2), 32'h1c00_0010, 5'd0);
    pulses = 0;
    bus.EX_allow = 0;
    sample(); check("beq_fire", bus.branch_bus, {1'b1, 32'h1c00_0020}); advance();
    sample(); check("beq_once", bus.branch_bus, 33'd0); advance();
    bus.EX_allow = 1;
    sample(); advance();
    check("beq_pulses", pulses, 1);

    // beq waiting on a load in EX
    send(mk(6'h16, 16'd8, 5'd1, 5'd2), 32'h1c00_0040, 5'd0);
    pulses = 0;
    bus.EX_fwd = {1'b1, 1'b1, 1'b1, 5'd1, 32'h0};
    repeat (3) begin
      sample();
      check("ld_stall", bus.ID_br_stall, 1'b1);
      check("ld_nobr", bus.branch_bus[32], 1'b0);
      advance();
    end
    bus.EX_fwd = '0;
    sample(); check("ld_fire", bus.branch_bus, {1'b1, 32'h1c00_0060}); advance();
    sample(); advance();
    check("ld_pulses", pulses, 1);

    // bl held by EX_allow=0 for three cycles
    send({6'h15, 16'd16, 10'd0}, 32'h1c00_0080, 5'd0);
    pulses = 0;
    bus.EX_allow = 0;
    bus.IF_to_ID_valid = 1;
    bus.IF_to_ID_bus = {32'h0, 32'h1c00_0084, 5'd0};
    repeat (3) begin
      sample(); check("bl_hold_allow", bus.ID_allow, 1'b0); advance();
    end
    idle();
    sample(); advance();
    check("bl_pulses", pulses, 1);

    // jirl r0,r1,0 with r1 produced in flight
    send(mk(6'h13, 16'd0, 5'd1, 5'd0), 32'h1c00_00f0, 5'd0);
`ifdef ID_FORWARD_EN
    bus.EX_fwd = {1'b1, 1'b1, 1'b0, 5'd1, 32'h1c00_0100};
`else
    rf[1] = 32'h1c00_0100;
    bus.WB_fwd = {1'b1, 1'b1, 5'd1, 32'h0};
    repeat (2) begin
      sample(); check("jirl_stall", bus.ID_br_stall, 1'b1); advance();
    end
    bus.WB_fwd = '0;
`endif
    sample(); check("jirl_target", bus.branch_bus, {1'b1, 32'h1c00_0100}); advance();
    idle();
    rf[1] = 32'd5;

    // flush during a stalled branch
    send(mk(6'h16, 16'd4, 5'd1, 5'd2), 32'h1c00_0200, 5'd0);
    pulses = 0;
    bus.EX_fwd = {1'b1, 1'b1, 1'b1, 5'd1, 32'h0};
    sample(); check("fl_stall", bus.ID_br_stall, 1'b1); advance();
    bus.flush = 1;
    sample(); check("fl_out_valid", bus.ID_to_EX_valid, 1'b0); advance();
    idle();
    sample();
    check("fl_id_valid", bus.dbg_id_valid, 1'b0);
    check("fl_allow", bus.ID_allow, 1'b1);
    advance();
    check("fl_pulses", pulses, 0);

    // adef word: no stall, exception passed on
    send(mk(6'h16, 16'd4, 5'd1, 5'd2), 32'h1c00_0300, 5'b10000);
    bus.EX_fwd = {1'b1, 1'b1, 1'b1, 5'd1, 32'h0};
    sample();
    check("adef_stall", bus.ID_br_stall, 1'b0);
    check("adef_out_valid", bus.ID_to_EX_valid, 1'b1);
    check("adef_ex4", bus.ID_to_EX_bus[4], 1'b1);
    check("adef_nobr", bus.branch_bus, 33'd0);
    advance();
    idle();

    // reset with a taken branch sitting in ID
    send({6'h14, 16'd2, 10'd0}, 32'h1c00_0400, 5'd0);
    pulses = 0;
    bus.EX_allow = 0;
    reset = 1;
    sample(); advance();
    reset = 0;
    idle();
    sample(); check("rst_mid_valid", bus.dbg_id_valid, 1'b0); advance();
    check("rst_mid_pulses", pulses, 0);

    // randomized traffic
    repeat (3000) begin
      rand_inputs();
      sample();
      advance();
    end
    reset = 0;
    idle();
    sample();
    advance();
    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-002 SHALL have IF_to_ID_valid in 1 and IF_to_ID_bus in 69, packed {inst[31:0], pc[31:0], adef, ex_ade, ex_tlbr, ex_pif, ex_ppi}.
REQ-003 SHALL have ID_allow out 1, meaning ID accepts a new IF word this cycle.
REQ-004 SHALL have EX_allow in 1, ID_to_EX_valid out 1 and ID_to_EX_bus out 133, packed {inst, pc, rj_val, rkd_val, ex[4:0]}.
REQ-005 SHALL have branch_bus out 33, packed {branch_valid, branch_pc[31:0]}, and ID_br_stall out 1.
REQ-006 SHALL have flush in 1, which is the OR of WB exception, ertn and reinst.
REQ-007 SHALL have rf_raddr1/rf_raddr2 out 5 each and rf_rdata1/rf_rdata2 in 32 each.
REQ-008 SHALL have EX_fwd in 40 {valid, we, is_load_or_csr, dest[4:0], data[31:0]}, MEM_fwd in 40 {valid, we, data_pending, dest, data} and WB_fwd in 39 {valid, we, dest, data}.

Function
REQ-009 SHALL latch the IF bus into its ID register on IF_to_ID_valid && ID_allow; ID_valid <= IF_to_ID_valid when ID_allow.
REQ-010 SHALL drive ID_allow = ~ID_valid | (ready_go & EX_allow), and ID_to_EX_valid = ID_valid & ready_go & ~flush.
REQ-011 SHALL set rf_raddr1 = inst[9:5] (rj).
REQ-012 SHALL set rf_raddr2 = inst[4:0] (rd) for conditional branches and for inst[31:24]==8'h29 stores, and inst[14:10] (rk) otherwise.
REQ-013 SHALL never treat source register 0 as a hazard and SHALL read it as 0.
REQ-014 SHALL select operands by priority EX > MEM > WB > regfile, matching on valid & we & dest==src.
REQ-015 SHALL deassert ready_go while ID_valid when any source matches an EX producer with is_load_or_csr or a MEM producer with data_pending.
REQ-016 SHALL decode by inst[31:26]: jirl 010011, b 010100, bl 010101, beq 010110, bne 010111, blt 011000, bge 011001, bltu 011010, bgeu 011011.
REQ-017 SHALL compute targets with 32-bit wraparound: pc+sext({offs16,2'b00}) for conditional branches, pc+sext({inst[9:0],inst[25:10],2'b00}) for b/bl, rj_val+sext({offs16,2'b00}) for jirl.
REQ-018 SHALL compare signed for blt/bge and unsigned for bltu/bgeu.
REQ-019 SHALL assert ID_br_stall = ID_valid & is_branch & ~ready_go.
REQ-020 SHALL assert branch_valid only when ID_valid & is_branch & taken & ready_go & ~br_done & ~flush.
REQ-021 SHALL set br_done when branch_valid fires and clear it when a new instruction is accepted, so each branch redirects exactly once even while EX_allow is low.
REQ-022 SHALL, when any of the five IF exception bits is set, suppress hazard stall and branch, and forward the exception bits in ex[4:0].
REQ-023 SHALL clear ID_valid and br_done on flush; flush SHALL take priority over simultaneous acceptance.

Reset
REQ-024 SHALL reset ID_valid=0, br_done=0 and ID register=0, so ID_allow=1, ID_to_EX_valid=0, branch_bus=0 and ID_br_stall=0.
REQ-025 SHALL discard any in-flight instruction when reset is asserted mid-operation, with no branch issued.

Configuration
REQ-026 SHALL provide macro ID_FORWARD_EN.
REQ-027 SHALL, with ID_FORWARD_EN defined, implement forwarding per REQ-014/015.
REQ-028 SHALL, without ID_FORWARD_EN, use regfile data only and stall on any valid & we & dest match in EX, MEM or WB.

Structure
REQ-029 SHALL place bus widths (IF_ID 69, ID_EX 133, FWD 40/39) and opcode constants in shared package pipe_pkg.
REQ-030 SHALL implement branch decode, comparison and target calculation as sub-module id_branch_unit.

Verification
REQ-031 SHALL cover: beq r1,r2 with both 5, pc=0x1c000010, offs16=4 -> branch_bus={1,0x1c000020} for exactly one cycle.
REQ-032 SHALL cover: beq with EX_fwd load dest=r1 -> ID_br_stall=1 and branch_valid=0 until the load clears, then branch fires once.
REQ-033 SHALL cover: EX_allow=0 for 3 cycles on a taken bl -> exactly one branch_valid pulse and ID_allow=0 throughout.
REQ-034 SHALL cover: jirl r0,r1,0 with EX_fwd data 0x1c000100 on r1 -> branch_pc=0x1c000100; without ID_FORWARD_EN -> stall until WB clears.
REQ-035 SHALL cover: flush during a stalled branch -> ID_valid=0 next cycle and no branch issued.
REQ-036 SHALL cover: IF bus with adef=1 -> no stall and ID_to_EX ex[4]=1.
